// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and arbiter state type for the GPU shared-memory path
package gpu_pkg;
  localparam int NUM_CORES = 16;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int ID_W = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_e;
endpackage

// File: rtl/sm_ram.sv
// sm_ram: single-port synchronous RAM with 1-cycle read latency
module sm_ram import gpu_pkg::*; (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter serialising single-byte core loads/stores onto shared RAM
module shared_mem_arbiter import gpu_pkg::*; (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_val,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id
);
  arb_state_e state, state_nx;
  logic [ID_W-1:0] rr_ptr, pick;
  logic has_req, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, ram_rdata;

  // scan downward so the requester closest to ptr is the last one kept
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req, input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] id;
    rr_pick = ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      id = ID_W'((int'(ptr) + i) % NUM_CORES);
      if (req[id]) rr_pick = id;
    end
  endfunction

  assign has_req = |core_req;
  assign pick = rr_pick(core_req, rr_ptr);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (has_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      grant_id <= '0;
      rr_ptr <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && has_req) begin
        grant_id <= pick;
        we_q <= core_we[pick];
        addr_q <= core_addr[pick*ADDR_W +: ADDR_W];
        wdata_q <= core_wdata[pick*DATA_W +: DATA_W];
      end
      if (state == RESP) begin
        rr_ptr <= grant_id == ID_W'(NUM_CORES - 1) ? '0 : grant_id + 1'b1;
        if (!we_q) rdata_q <= ram_rdata;
      end
    end

  // load data comes straight from the RAM during RESP, then is held so stores leave it unchanged
  assign busy = state != IDLE;
  assign core_val = state == RESP ? NUM_CORES'(1) << grant_id : '0;
  assign core_rdata = (state == RESP && !we_q) ? ram_rdata : rdata_q;

  sm_ram u_ram (
    .clk  (clk),
    .we   (state == ACCESS && we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: scoreboard bench with a queue-level round-robin and memory model
module tb_shared_mem_arbiter;
  import gpu_pkg::*;
  logic clk = 0, reset = 1;
  logic [NUM_CORES-1:0] core_req = '0, core_we = '0, core_val;
  logic [NUM_CORES*ADDR_W-1:0] core_addr = '0;
  logic [NUM_CORES*DATA_W-1:0] core_wdata = '0;
  logic [DATA_W-1:0] core_rdata;
  logic busy;
  logic [ID_W-1:0] grant_id;
  typedef struct {int id; bit we; logic [DATA_W-1:0] rdata;} exp_t;
  exp_t q[$];
  exp_t me;
  logic [DATA_W-1:0] mem[MEM_DEPTH];
  bit vld[MEM_DEPTH];
  logic op_we[NUM_CORES];
  logic [ADDR_W-1:0] op_addr[NUM_CORES];
  logic [DATA_W-1:0] op_wdata[NUM_CORES];
  logic [ADDR_W-1:0] pool[8];
  logic [NUM_CORES-1:0] prev_val = '0;
  int rr = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_val(core_val),
    .core_rdata(core_rdata), .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && core_val !== '0) begin
      chk("val_one_cycle", 32'(prev_val), 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_val actual=%0h required=none", core_val);
      end else begin
        me = q.pop_front();
        chk("core_val", 32'(core_val), 1 << me.id);
        chk("grant_id", 32'(grant_id), me.id);
        if (!me.we) chk("core_rdata", 32'(core_rdata), 32'(me.rdata));
      end
    end
    prev_val = core_val;
  end

  task automatic set_op(input int id, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    op_we[id] = we;
    op_addr[id] = a;
    op_wdata[id] = d;
  endtask

  task automatic plan(input logic [NUM_CORES-1:0] mask);
    exp_t e;
    int id, last;
    last = rr;
    for (int k = 0; k < NUM_CORES; k++) begin
      id = (rr + k) % NUM_CORES;
      if (mask[id]) begin
        if (!op_we[id] && !vld[op_addr[id]]) op_we[id] = 1;
        e.id = id;
        e.we = op_we[id];
        e.rdata = mem[op_addr[id]];
        if (op_we[id]) begin
          mem[op_addr[id]] = op_wdata[id];
          vld[op_addr[id]] = 1;
        end
        q.push_back(e);
        last = id;
      end
    end
    if (mask != 0) rr = (last + 1) % NUM_CORES;
  endtask

  task automatic drive(input logic [NUM_CORES-1:0] mask);
    for (int i = 0; i < NUM_CORES; i++) begin
      core_we[i] = op_we[i];
      core_addr[i*ADDR_W +: ADDR_W] = op_addr[i];
      core_wdata[i*DATA_W +: DATA_W] = op_wdata[i];
    end
    core_req = mask;
  endtask

  task automatic run_batch(input logic [NUM_CORES-1:0] mask, input logic [NUM_CORES-1:0] early_drop);
    int n = 0, first_n = -1, idles = 0;
    plan(mask);
    @(negedge clk);
    drive(mask);
    while (core_req != 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) core_req &= ~early_drop;
      if (core_val != 0 && first_n < 0) first_n = n;
      if (!busy && core_req != 0) idles++;
      core_req &= ~core_val;
    end
    if (core_req != 0) begin
      checks++;
      failures++;
      $display("FAIL batch_timeout actual=%0h required=0", core_req);
      core_req = '0;
    end
    if (first_n >= 0) chk("latency", first_n, 2);
    if (early_drop == 0) chk("idle_gaps", idles, $countones(mask) - 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [NUM_CORES-1:0] m;
    for (int i = 0; i < 8; i++) pool[i] = ADDR_W'($urandom);
    for (int i = 0; i < NUM_CORES; i++) set_op(i, 0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_val", 32'(core_val), 0);
    chk("rst_rdata", 32'(core_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    reset = 0;
    set_op(0, 1, 12'hABC, 8'h5A);
    run_batch(16'h0001, 0);
    set_op(1, 0, 12'hABC, 8'h00);
    run_batch(16'h0002, 0);
    set_op(2, 0, 12'hABC, 0); set_op(5, 0, 12'hABC, 0); set_op(9, 0, 12'hABC, 0);
    run_batch(16'h0224, 0);
    set_op(3, 0, 12'hABC, 0); set_op(12, 0, 12'hABC, 0);
    run_batch(16'h1008, 0);
    set_op(14, 0, 12'hABC, 0);
    run_batch(16'h4000, 0);
    for (int i = 0; i < NUM_CORES; i++) set_op(i, 1, 12'h100 + 12'(i), 8'(8'h40 + i));
    run_batch(16'hFFFF, 0);
    set_op(7, 1, 12'h000, 8'h11); run_batch(16'h0080, 0);
    set_op(7, 1, 12'hFFF, 8'hEE); run_batch(16'h0080, 0);
    set_op(7, 0, 12'h000, 0); run_batch(16'h0080, 0);
    set_op(7, 0, 12'hFFF, 0); run_batch(16'h0080, 0);
    set_op(4, 1, 12'h123, 8'h33); run_batch(16'h0010, 16'h0010);
    set_op(4, 0, 12'h123, 0); run_batch(16'h0010, 0);
    set_op(6, 1, 12'h010, 8'h22); run_batch(16'h0040, 0);
    set_op(6, 1, 12'h010, 8'h77);
    @(negedge clk);
    drive(16'h0040);
    @(negedge clk);
    chk("access_busy", 32'(busy), 1);
    chk("access_grant", 32'(grant_id), 6);
    #1 reset = 1;
    #1;
    chk("midrst_val", 32'(core_val), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_grant", 32'(grant_id), 0);
    core_req = '0;
    rr = 0;
    @(negedge clk);
    reset = 0;
    set_op(6, 0, 12'h010, 0); run_batch(16'h0040, 0);
    for (int b = 0; b < 30; b++) begin
      m = NUM_CORES'($urandom);
      if (m == 0) m = 16'h8000;
      for (int i = 0; i < NUM_CORES; i++)
        set_op(i, 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom));
      run_batch(m, 0);
    end
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
